// File: rtl/relu_maxpool1_if.sv
// Stream bundle for relu_maxpool1: raw conv beats in, pooled beats out.
interface relu_maxpool1_if #(
   parameter int DATA_W = 8,
   parameter int CH     = 4
);
   logic [CH*DATA_W-1:0] in_data;
   logic                 in_valid;
   logic [CH*DATA_W-1:0] out_data;
   logic                 out_valid;
   logic                 out_last;

   modport master (
      output in_data,
      output in_valid,
      input  out_data,
      input  out_valid,
      input  out_last
   );

   modport slave (
      input  in_data,
      input  in_valid,
      output out_data,
      output out_valid,
      output out_last
   );
endinterface

// File: rtl/relu_maxpool1.sv
// ReLU + per-channel 1-D max-pool after conv layer 1, with row/layer framing.
// Fully registered: outputs change one clk after the closing input beat.
module relu_maxpool1 #(
   parameter int DATA_W     = 8,
   parameter int CH         = 4,
   parameter int POOL       = 2,
   parameter int FRAME_LEN  = 61,
   parameter int NUM_FRAMES = 42
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             soft_clr,
   relu_maxpool1_if.slave   bus,
   output logic             done
);

   localparam int PW = (POOL > 1) ? $clog2(POOL) : 1;
   localparam int XW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam int FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;

   typedef enum logic {
      RUN  = 1'b0,
      DONE = 1'b1
   } state_t;

   typedef logic [CH-1:0][DATA_W-1:0] vec_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   pool_q, pool_d;
   logic [XW-1:0]   pos_q, pos_d;
   logic [FW-1:0]   frame_q, frame_d;
   vec_t            acc_q, acc_d;
   vec_t            odat_q, odat_d;
   logic            oval_q, oval_d;
   logic            olast_q, olast_d;
   logic            done_q, done_d;

   vec_t            relu;
   vec_t            upd;
   logic            first;
   logic            pool_end;
   logic            pos_end;
   logic            frame_end;

   assign first     = (pool_q == '0);
   assign pool_end  = (pool_q == PW'(POOL-1));
   assign pos_end   = (pos_q == XW'(FRAME_LEN-1));
   assign frame_end = (frame_q == FW'(NUM_FRAMES-1));

   // Clamped values are non-negative, so an unsigned max is correct.
   always_comb begin
      relu = '0;
      upd  = '0;
      for (int c = 0; c < CH; c++) begin
         relu[c] = bus.in_data[c*DATA_W+DATA_W-1] ?
                   '0 : bus.in_data[c*DATA_W +: DATA_W];
         if (first || (relu[c] > acc_q[c])) begin
            upd[c] = relu[c];
         end else begin
            upd[c] = acc_q[c];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      pool_d  = pool_q;
      pos_d   = pos_q;
      frame_d = frame_q;
      acc_d   = acc_q;
      odat_d  = odat_q;
      oval_d  = 1'b0;
      olast_d = 1'b0;
      done_d  = done_q;

      if (soft_clr) begin
         state_d = RUN;
         pool_d  = '0;
         pos_d   = '0;
         frame_d = '0;
         acc_d   = '0;
         odat_d  = '0;
         done_d  = 1'b0;
      end else begin
         unique case (state_q)
            RUN: begin
               if (bus.in_valid) begin
                  acc_d = upd;
                  if (pool_end || pos_end) begin
                     odat_d = upd;
                     oval_d = 1'b1;
                     pool_d = '0;
                  end else begin
                     pool_d = pool_q + 1'b1;
                  end
                  if (pos_end) begin
                     pos_d   = '0;
                     olast_d = 1'b1;
                     if (frame_end) begin
                        frame_d = '0;
                        done_d  = 1'b1;
                        state_d = DONE;
                     end else begin
                        frame_d = frame_q + 1'b1;
                     end
                  end else begin
                     pos_d = pos_q + 1'b1;
                  end
               end
            end
            DONE: begin
               state_d = DONE;
            end
            default: begin
               state_d = RUN;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         pool_q  <= '0;
         pos_q   <= '0;
         frame_q <= '0;
         acc_q   <= '0;
         odat_q  <= '0;
         oval_q  <= 1'b0;
         olast_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pool_q  <= pool_d;
         pos_q   <= pos_d;
         frame_q <= frame_d;
         acc_q   <= acc_d;
         odat_q  <= odat_d;
         oval_q  <= oval_d;
         olast_q <= olast_d;
         done_q  <= done_d;
      end
   end

   assign bus.out_data  = odat_q;
   assign bus.out_valid = oval_q;
   assign bus.out_last  = olast_q;
   assign done          = done_q;

endmodule

// File: tb/tb_relu_maxpool1.sv
// Directed bench for relu_maxpool1 with hand-computed expectations.
module tb_relu_maxpool1;

   logic clk = 1'b0;
   logic rst_n;
   logic soft_clr;
   logic done;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   relu_maxpool1_if #(.DATA_W(8), .CH(4)) bus ();

   relu_maxpool1 #(
      .DATA_W(8),
      .CH(4),
      .POOL(2),
      .FRAME_LEN(61),
      .NUM_FRAMES(42)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .soft_clr(soft_clr),
      .bus(bus.slave),
      .done(done)
   );

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Apply one cycle of input, then sample #1 after the edge.
   task automatic cyc(input logic v, input logic [31:0] d);
      bus.in_valid = v;
      bus.in_data  = d;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_data"}, bus.out_data, 32'h0);
      chk({tag, "_valid"}, {31'h0, bus.out_valid}, 32'h0);
      chk({tag, "_last"}, {31'h0, bus.out_last}, 32'h0);
      chk({tag, "_done"}, {31'h0, done}, 32'h0);
   endtask

   task automatic do_reset();
      soft_clr     = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      rst_n        = 1'b0;
      #3;
      chk_zero("rst_low");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk_zero("rst_rel");
   endtask

   int pulses;
   int lasts;
   int early;
   int badlast;

   initial begin
      do_reset();

      // basic back-to-back pair
      cyc(1'b1, 32'h107F8005);
      chk("pair_b1_valid", {31'h0, bus.out_valid}, 32'h0);
      cyc(1'b1, 32'h1000F009);
      chk("pair_valid", {31'h0, bus.out_valid}, 32'h1);
      chk("pair_data", bus.out_data, 32'h107F0009);
      chk("pair_last", {31'h0, bus.out_last}, 32'h0);
      cyc(1'b0, 32'h0);
      chk("pair_pulse", {31'h0, bus.out_valid}, 32'h0);
      chk("pair_hold", bus.out_data, 32'h107F0009);

      // same pair with three idle cycles inside the window
      cyc(1'b1, 32'h107F8005);
      pulses = 0;
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 32'hFFFFFFFF);
         if (bus.out_valid) pulses++;
      end
      chk("gap_idle", pulses, 0);
      cyc(1'b1, 32'h1000F009);
      chk("gap_valid", {31'h0, bus.out_valid}, 32'h1);
      chk("gap_data", bus.out_data, 32'h107F0009);
      cyc(1'b0, 32'h0);
      chk("gap_pulse", {31'h0, bus.out_valid}, 32'h0);

      // async reset in the middle of a window drops it
      cyc(1'b1, 32'h0000007F);
      #2;
      rst_n = 1'b0;
      #1;
      chk_zero("mid_rst");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk_zero("mid_rel");
      cyc(1'b1, 32'h00000001);
      chk("mid_b1_valid", {31'h0, bus.out_valid}, 32'h0);
      cyc(1'b1, 32'h00000002);
      chk("mid_valid", {31'h0, bus.out_valid}, 32'h1);
      chk("mid_data", bus.out_data, 32'h00000002);

      // one row: ch0 = index, tail window of one element
      do_reset();
      pulses  = 0;
      badlast = 0;
      for (int k = 0; k < 61; k++) begin
         cyc(1'b1, k);
         if (bus.out_valid) begin
            if (pulses < 30) begin
               chk("row_data", bus.out_data, 2 * pulses + 1);
            end else begin
               chk("row_tail_data", bus.out_data, 32'd60);
            end
            chk("row_last", {31'h0, bus.out_last},
                (pulses == 30) ? 32'h1 : 32'h0);
            pulses++;
         end else if (bus.out_last) begin
            badlast++;
         end
      end
      chk("row_pulses", pulses, 31);
      chk("row_stray_last", badlast, 0);

      // full layer, then beats after done
      do_reset();
      pulses = 0;
      lasts  = 0;
      early  = 0;
      for (int b = 0; b < 42 * 61; b++) begin
         cyc(1'b1, b % 128);
         if (bus.out_valid) pulses++;
         if (bus.out_last) lasts++;
         if (done && b < 42 * 61 - 1) early++;
      end
      chk("lay_pulses", pulses, 42 * 31);
      chk("lay_lasts", lasts, 42);
      chk("lay_done", {31'h0, done}, 32'h1);
      chk("lay_final_last", {31'h0, bus.out_last}, 32'h1);
      chk("lay_final_valid", {31'h0, bus.out_valid}, 32'h1);
      chk("lay_early_done", early, 0);
      pulses = 0;
      for (int b = 0; b < 10; b++) begin
         cyc(1'b1, 32'h55555555);
         if (bus.out_valid) pulses++;
      end
      chk("post_pulses", pulses, 0);
      chk("post_done", {31'h0, done}, 32'h1);
      soft_clr = 1'b1;
      cyc(1'b1, 32'h11111111);
      soft_clr = 1'b0;
      chk_zero("clr_done");

      // soft_clr discards a beat and restarts framing
      do_reset();
      cyc(1'b1, 32'h00000001);
      chk("sc_b1_valid", {31'h0, bus.out_valid}, 32'h0);
      soft_clr = 1'b1;
      cyc(1'b1, 32'h00000005);
      soft_clr = 1'b0;
      chk("sc_valid", {31'h0, bus.out_valid}, 32'h0);
      chk("sc_done", {31'h0, done}, 32'h0);
      cyc(1'b1, 32'h00000003);
      chk("sc_p0_valid", {31'h0, bus.out_valid}, 32'h0);
      cyc(1'b1, 32'h00000001);
      chk("sc_p1_valid", {31'h0, bus.out_valid}, 32'h1);
      chk("sc_p1_data", bus.out_data, 32'h00000003);
      chk("sc_p1_last", {31'h0, bus.out_last}, 32'h0);
      lasts = 0;
      for (int k = 2; k < 61; k++) begin
         cyc(1'b1, 32'h0);
         if (bus.out_last) lasts++;
      end
      chk("sc_row_lasts", lasts, 1);
      chk("sc_row_end", {31'h0, bus.out_last}, 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
